pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
- Receive-side counterpart of the team's pulse generator: measures the clock-cycle distance between consecutive rising edges of an asynchronous pulse input.
- Reports each measurement through a valid/ready output register.
- Flags measurement overflow and results dropped under backpressure.
- Used for loopback checks of pulse generators and for measuring external periodic signals.

Parameters:
- N, 8: width of the period counter and of the period output; maximum measurable period is 2^N-1 cycles.
- SYNC_STAGES, 2: number of flops in the input synchronizer; minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- ena  input  1  measurement enable.
- pulse_in  input  1  asynchronous pulse input.
- period  output  N  measured rising-edge-to-rising-edge distance, in cycles.
- period_valid  output  1  period holds an unconsumed result.
- period_ready  input  1  consumer accepts the result this cycle.
- overflow  output  1  high while in the OVERFLOW state.
- dropped  output  1  sticky flag: a result was lost to backpressure.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Synchronizer flops, previous-sample flop and counter clear to 0.
  - State goes to IDLE.
  - period=0, period_valid=0, overflow=0, dropped=0.
  - Reset overrides everything, including a pending unconsumed result.
- Synchronizer and edge detect:
  - pulse_in passes through SYNC_STAGES flops, which run regardless of ena.
  - Edge event = sync_out & ~sync_prev.
- State IDLE:
  - counter=0.
  - Edge with ena=1 -> counter<=1, go to MEASURE.
  - No result is produced.
- State MEASURE:
  - No edge -> counter<=counter+1.
  - Edge -> capture counter as the result, counter<=1, stay in MEASURE.
  - Edges at cycles t and t+P produce period=P. Minimum P is 2.
  - No edge while counter==2^N-1 -> go to OVERFLOW. No result is produced and the counter never wraps.
- State OVERFLOW:
  - overflow=1 and the counter is frozen.
  - Edge -> counter<=1, go to MEASURE, overflow falls on the same clock.
  - No result is produced for the overflowed interval.
- ena=0:
  - Any state -> IDLE next clock, counter<=0, overflow<=0.
  - Edges seen while ena=0 are ignored.
  - The output register and dropped are unaffected; a pending result stays valid until consumed.
- Output handshake:
  - The slot is free when period_valid=0 or period_ready=1.
  - Capture with slot free -> period<=result, period_valid<=1 on that clock.
  - Capture with slot busy -> result discarded, dropped<=1. dropped clears only on rst.
  - No capture and period_ready=1 -> period_valid<=0.
  - While period_valid=1 and period_ready=0, period is held stable.
  - Capture coinciding with ready: the new value loads and valid stays 1, so back-to-back transfers are allowed.
- Latency:
  - A rising pulse_in first sampled at clock k gives its edge event in the cycle after clock k+SYNC_STAGES-1.
  - The resulting period_valid rises at clock k+SYNC_STAGES.
- Arithmetic: the counter is unsigned N bits, with no wrap, saturating into OVERFLOW.

Test Plan:
- Square wave, 4 cycles high / 4 low, ena=1, period_ready=1 -> first edge yields nothing; every later edge gives a one-cycle period_valid with period=8; dropped=0, overflow=0.
- Same wave with period_ready=0 across two captures -> period=8 is held with valid=1 and dropped=1; raising ready for one cycle drops valid on the next clock.
- N=4, rising edges 20 cycles apart -> overflow=1 starting 16 cycles after the first edge with no result emitted; the next edge clears overflow; a following edge 10 cycles later reports period=10.
- ena=1, one edge, 3 cycles, ena=0 for 5 cycles with one edge inside, ena=1, edge, edge 6 cycles later -> exactly one result, period=6.
- period_valid=1 pending, dropped=1, state MEASURE, then rst pulsed -> next cycle all outputs 0 and state IDLE; the next two edges 8 apart give period=8.
- Loopback from the team's pulse generator (ticks=3, ena=1) to pulse_in -> steady stream of period=8, one result per generator rising edge, no overflow or dropped.

Source files
------------

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
// Measures the clock-cycle distance between consecutive rising edges of an
// asynchronous pulse input and hands each measurement to a consumer through a
// single valid/ready output register.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-high reset
//   ena          measurement enable; low forces IDLE and ignores edges
//   pulse_in     asynchronous pulse input
//   period       last captured rising-edge-to-rising-edge distance (cycles)
//   period_valid period holds an unconsumed result
//   period_ready consumer accepts the result this cycle
//   overflow     high while the current interval exceeded 2^N-1 cycles
//   dropped      sticky: a result was discarded because the slot was busy
module pulse_period_meter #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         overflow,
  output logic         dropped
);

  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE  = N'(1);
  localparam logic [N-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_OVERFLOW
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_prev_p1;
  logic                   edge_p1;
  logic [N-1:0]           cnt, cnt_nxt;
  logic                   capture;
  logic                   slot_free;

  // Counter increment that refuses to wrap past the all-ones value.
  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Stage 0: input synchronizer, runs regardless of ena
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0      <= '0;
      sync_prev_p1 <= 1'b0;
    end else begin
      sync_p0      <= {sync_p0[SYNC_STAGES-2:0], pulse_in};
      sync_prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  // Stage 1: edge detect, measurement FSM and counter
  assign edge_p1 = sync_p0[SYNC_STAGES-1] & ~sync_prev_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!ena) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = CNT_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = CNT_ZERO;
          if (edge_p1) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (edge_p1) begin
            capture = 1'b1;
            cnt_nxt = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            // Interval too long to represent: freeze and wait for a fresh edge.
            state_nxt = ST_OVERFLOW;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        ST_OVERFLOW: begin
          if (edge_p1) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_MEASURE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  assign overflow = (state == ST_OVERFLOW);

  // Stage 2: output register with valid/ready handshake
  assign slot_free = ~period_valid | period_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      period       <= CNT_ZERO;
      period_valid <= 1'b0;
      dropped      <= 1'b0;
    end else if (capture) begin
      if (slot_free) begin
        period       <= cnt;
        period_valid <= 1'b1;
      end else begin
        dropped <= 1'b1;
      end
    end else if (period_ready) begin
      period_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter. Two instances (N=8 and N=4)
// share all inputs; a timestamp-based reference model predicts both.
module tb_pulse_period_meter;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       pulse_in = 1'b0;
  logic       period_ready = 1'b0;
  logic [7:0] period8;
  logic       valid8, ovf8, drop8;
  logic [3:0] period4;
  logic       valid4, ovf4, drop4;

  pulse_period_meter #(.N(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .period(period8), .period_valid(valid8), .period_ready(period_ready),
    .overflow(ovf8), .dropped(drop8)
  );

  pulse_period_meter #(.N(4), .SYNC_STAGES(S)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .period(period4), .period_valid(valid4), .period_ready(period_ready),
    .overflow(ovf4), .dropped(drop4)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int xfer8 = 0;
  int xfer4 = 0;
  bit v8_prev = 0;
  bit v4_prev = 0;

  // Reference model: index 0 is the N=8 instance, index 1 the N=4 instance.
  int   cyc = 0;
  bit [S:0] hist = '0;
  bit   m_armed [2];
  int   m_last  [2];
  bit   m_ovf   [2];
  bit   m_valid [2];
  int   m_per   [2];
  bit   m_drop  [2];
  int   m_max   [2] = '{255, 15};

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    bit e;
    bit cap;
    int res;
    e = hist[S-1] & ~hist[S];
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        m_armed[j] = 0; m_last[j] = 0; m_ovf[j] = 0;
        m_valid[j] = 0; m_per[j] = 0; m_drop[j] = 0;
      end else begin
        cap = 0;
        res = 0;
        if (!ena) begin
          m_armed[j] = 0;
          m_ovf[j]   = 0;
        end else if (e) begin
          if (m_armed[j] && !m_ovf[j]) begin
            cap = 1;
            res = cyc - m_last[j];
          end
          m_armed[j] = 1;
          m_last[j]  = cyc;
          m_ovf[j]   = 0;
        end else if (m_armed[j] && !m_ovf[j] && (cyc - m_last[j]) >= m_max[j]) begin
          m_ovf[j] = 1;
        end
        if (cap) begin
          if (!m_valid[j] || period_ready) begin
            m_per[j]   = res;
            m_valid[j] = 1;
          end else begin
            m_drop[j] = 1;
          end
        end else if (period_ready) begin
          m_valid[j] = 0;
        end
      end
    end
    if (rst) hist = '0;
    else     hist = {hist[S-1:0], pulse_in};
    cyc++;
  endtask

  task automatic step();
    if (v8_prev && period_ready) xfer8++;
    if (v4_prev && period_ready) xfer4++;
    @(posedge clk);
    model_update();
    #1;
    v8_prev = valid8;
    v4_prev = valid4;
    chk("period8", int'(period8), m_per[0]);
    chk("valid8",  int'(valid8),  int'(m_valid[0]));
    chk("ovf8",    int'(ovf8),    int'(m_ovf[0]));
    chk("drop8",   int'(drop8),   int'(m_drop[0]));
    chk("period4", int'(period4), m_per[1]);
    chk("valid4",  int'(valid4),  int'(m_valid[1]));
    chk("ovf4",    int'(ovf4),    int'(m_ovf[1]));
    chk("drop4",   int'(drop4),   int'(m_drop[1]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    xfer8 = 0;
    xfer4 = 0;
  endtask

  // Square wave starting low for lo cycles, then high for hi, then a low tail.
  task automatic run_wave(input int hi, input int lo, input int cycles, input bit rdy);
    period_ready = rdy;
    for (int i = 0; i < cycles; i++) begin
      pulse_in = ((i % (hi + lo)) >= lo);
      step();
    end
    pulse_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  typedef struct {
    int hi; int lo; int cycles; bit rdy;
    int exp_xfer8; int exp_per8; int exp_xfer4; int exp_per4;
    int exp_drop;  int exp_valid;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 4, 40, 1, 4, 8, 4, 8, 0, 0};
    vecs[1] = '{1, 1, 20, 1, 9, 2, 9, 2, 0, 0};
    vecs[2] = '{3, 12, 45, 1, 2, 15, 2, 15, 0, 0};
    vecs[3] = '{2, 14, 50, 1, 2, 16, 0, 0, 0, 0};
    vecs[4] = '{4, 4, 40, 0, 0, 8, 0, 8, 1, 1};

    ena = 1'b1;
    do_reset();
    chk("rst_period", int'(period8), 0);
    chk("rst_valid",  int'(valid8),  0);
    chk("rst_ovf",    int'(ovf8),    0);
    chk("rst_drop",   int'(drop8),   0);

    for (int v = 0; v < 5; v++) begin
      ena = 1'b1;
      pulse_in = 1'b0;
      do_reset();
      run_wave(vecs[v].hi, vecs[v].lo, vecs[v].cycles, vecs[v].rdy);
      chk($sformatf("vec%0d_xfer8", v),  xfer8,          vecs[v].exp_xfer8);
      chk($sformatf("vec%0d_per8", v),   int'(period8),  vecs[v].exp_per8);
      chk($sformatf("vec%0d_xfer4", v),  xfer4,          vecs[v].exp_xfer4);
      chk($sformatf("vec%0d_per4", v),   int'(period4),  vecs[v].exp_per4);
      chk($sformatf("vec%0d_drop8", v),  int'(drop8),    vecs[v].exp_drop);
      chk($sformatf("vec%0d_drop4", v),  int'(drop4),    vecs[v].exp_drop);
      chk($sformatf("vec%0d_valid8", v), int'(valid8),   vecs[v].exp_valid);
      chk($sformatf("vec%0d_valid4", v), int'(valid4),   vecs[v].exp_valid);
    end

    // One cycle of ready releases the held result.
    period_ready = 1'b1;
    step();
    chk("release_valid", int'(valid8), 0);
    chk("release_drop",  int'(drop8),  1);

    // Reset with a pending result and sticky drop set.
    run_wave(4, 4, 30, 0);
    chk("pre_rst_valid", int'(valid8), 1);
    chk("pre_rst_drop",  int'(drop8),  1);
    rst = 1'b1;
    pulse_in = 1'b1;
    step();
    rst = 1'b0;
    pulse_in = 1'b0;
    chk("post_rst_period", int'(period8), 0);
    chk("post_rst_valid",  int'(valid8),  0);
    chk("post_rst_drop",   int'(drop8),   0);
    chk("post_rst_ovf",    int'(ovf8),    0);
    xfer8 = 0;
    run_wave(4, 4, 24, 1);
    chk("post_rst_xfer8", xfer8, 2);
    chk("post_rst_per8",  int'(period8), 8);

    // Overflow on the N=4 instance: edges at 0, 20, 30.
    do_reset();
    period_ready = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      pulse_in = (i == 0 || i == 20 || i == 30);
      step();
      if (i == 16) chk("ovf4_before", int'(ovf4), 0);
      if (i == 17) chk("ovf4_rise",   int'(ovf4), 1);
      if (i == 21) chk("ovf4_held",   int'(ovf4), 1);
      if (i == 22) chk("ovf4_fall",   int'(ovf4), 0);
      if (i == 32) chk("ovf4_valid",  int'(valid4), 1);
      if (i == 32) chk("ovf4_period", int'(period4), 10);
    end
    chk("ovf4_xfer", xfer4, 1);

    // Edges while disabled are ignored; measurement restarts after ena.
    do_reset();
    period_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ena = !(i >= 3 && i <= 7);
      pulse_in = (i == 0 || i == 5 || i == 10 || i == 16);
      step();
    end
    chk("ena_xfer8", xfer8, 1);
    chk("ena_per8",  int'(period8), 6);

    // Randomized traffic against the reference model.
    ena = 1'b1;
    do_reset();
    begin
      int left;
      left = 0;
      for (int i = 0; i < 4000; i++) begin
        if (left == 0) begin
          pulse_in = ~pulse_in;
          left = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 200)
                                             : $urandom_range(1, 12);
        end
        left--;
        ena = ($urandom_range(0, 49) != 0);
        period_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 299) == 0);
        step();
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
